// File: rtl/dtg_param.sv
// Parametrised display timing generator: H/V counters, registered sync/video decode and strobes.
// Optional frame counter port enabled by defining DTG_FRAME_CNT_EN.
module dtg_param #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned H_WIN    = 640,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 11
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          pix_en,
    input  logic          enable,
    output logic          horiz_sync,
    output logic          vert_sync,
    output logic          video_on,
    output logic [CW-1:0] pixel_column,
    output logic [CW-1:0] pixel_row,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
`ifdef DTG_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] H_WIN_C  = CW'(H_WIN);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d, row_q, row_d;
    logic            hs_q, hs_d, vs_q, vs_d, vid_q, vid_d;
    logic            ls_q, ls_d, fs_q, fs_d;
    logic            active, eol, eof;
`ifdef DTG_FRAME_CNT_EN
    logic [15:0]     fc_q, fc_d;
`endif

    assign active = (state_q != StIdle);
    assign eol    = (col_q == H_LAST);
    assign eof    = eol && (row_q == V_LAST);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        vid_d   = vid_q;
        ls_d    = ls_q;
        fs_d    = fs_q;
`ifdef DTG_FRAME_CNT_EN
        fc_d    = fc_q;
`endif
        if (pix_en) begin
            ls_d = 1'b0;
            fs_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Counters already sit at 0, so the first RUN tick is itself a frame start
                    if (enable) begin
                        state_d = StRun;
                        ls_d    = 1'b1;
                        fs_d    = 1'b1;
                    end
                end
                StRun, StDrain: begin
                    col_d = eol ? '0 : col_q + 1'b1;
                    if (eol) begin
                        row_d = eof ? '0 : row_q + 1'b1;
                    end
                    if (enable) begin
                        state_d = StRun;
                    end else if (state_q == StDrain && eof) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDrain;
                    end
                    // Halting at the frame boundary produces no strobes
                    ls_d = eol && (state_d != StIdle);
                    fs_d = eof && (state_d != StIdle);
                end
                default: state_d = StIdle;
            endcase
            hs_d  = (active && col_q >= HS_FIRST && col_q <= HS_LAST) ? HS_POL : ~HS_POL;
            vs_d  = (active && row_q >= VS_FIRST && row_q <= VS_LAST) ? VS_POL : ~VS_POL;
            vid_d = active && (col_q < H_WIN_C) && (row_q < V_ACT_C);
`ifdef DTG_FRAME_CNT_EN
            if (fs_d) begin
                fc_d = fc_q + 16'd1;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            vid_q   <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
`ifdef DTG_FRAME_CNT_EN
            fc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vid_q   <= vid_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
`ifdef DTG_FRAME_CNT_EN
            fc_q    <= fc_d;
`endif
        end
    end

    assign horiz_sync   = hs_q;
    assign vert_sync    = vs_q;
    assign video_on     = vid_q;
    assign pixel_column = col_q;
    assign pixel_row    = row_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign running      = active;
`ifdef DTG_FRAME_CNT_EN
    assign frame_count  = fc_q;
`endif

endmodule

// File: tb/tb_dtg_param.sv
// Bench for dtg_param on a shrunken 15x9 raster: per-cycle model compare plus literal timing checks.
`timescale 1ns/1ps
module tb_dtg_param;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VA = 5, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HW = 6, CW = 5;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int HT = 15, VT = 9, FT = 135;

    logic          clk = 1'b0, rst = 1'b1, pix_en = 1'b1, enable = 1'b0;
    logic          horiz_sync, vert_sync, video_on, line_start, frame_start, running;
    logic [CW-1:0] pixel_column, pixel_row;
`ifdef DTG_FRAME_CNT_EN
    logic [15:0]   frame_count;
`endif

    int vectors = 0, miscompares = 0;
    bit chk_on = 1'b0, div4 = 1'b0;
    int phase = 0;

    always #5 clk = ~clk;

    dtg_param #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_WIN(HW), .HS_POL(HP), .VS_POL(VP), .CW(CW)
    ) dut (
        .clock(clk), .rst(rst), .pix_en(pix_en), .enable(enable),
        .horiz_sync(horiz_sync), .vert_sync(vert_sync), .video_on(video_on),
        .pixel_column(pixel_column), .pixel_row(pixel_row),
        .line_start(line_start), .frame_start(frame_start), .running(running)
`ifdef DTG_FRAME_CNT_EN
        , .frame_count(frame_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame as a single tick index; outputs derived arithmetically.
    int         m_pos = 0;
    bit         m_act = 1'b0, m_drain = 1'b0;
    logic       e_hs = ~HP, e_vs = ~VP, e_vid = 1'b0, e_ls = 1'b0, e_fs = 1'b0;
    logic [15:0] e_fc = '0;

    always @(posedge clk) begin : model
        int c, r;
        if (rst) begin
            m_pos = 0; m_act = 1'b0; m_drain = 1'b0;
            e_hs = ~HP; e_vs = ~VP; e_vid = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_fc = '0;
        end else if (pix_en) begin
            c = m_pos % HT;
            r = m_pos / HT;
            e_hs  = (m_act && c >= HA + HF && c < HA + HF + HS) ? HP : ~HP;
            e_vs  = (m_act && r >= VA + VF && r < VA + VF + VS) ? VP : ~VP;
            e_vid = m_act && c < HW && r < VA;
            e_ls = 1'b0;
            e_fs = 1'b0;
            if (!m_act) begin
                if (enable) begin
                    m_act = 1'b1; m_drain = 1'b0; e_ls = 1'b1; e_fs = 1'b1;
                end
            end else if (m_drain && !enable && m_pos == FT - 1) begin
                m_act = 1'b0; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FT;
                e_ls = (m_pos % HT == 0);
                e_fs = (m_pos == 0);
                m_drain = !enable;
            end
            if (e_fs) e_fc = e_fc + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("column", 32'(pixel_column), 32'(m_pos % HT));
            check("row", 32'(pixel_row), 32'(m_pos / HT));
            check("hsync", 32'(horiz_sync), 32'(e_hs));
            check("vsync", 32'(vert_sync), 32'(e_vs));
            check("video_on", 32'(video_on), 32'(e_vid));
            check("line_start", 32'(line_start), 32'(e_ls));
            check("frame_start", 32'(frame_start), 32'(e_fs));
            check("running", 32'(running), 32'(m_act));
`ifdef DTG_FRAME_CNT_EN
            check("frame_count", 32'(frame_count), 32'(e_fc));
`endif
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (div4) begin
                pix_en = (phase == 0);
                phase  = (phase + 1) % 4;
            end else begin
                pix_en = 1'b1;
            end
        end
    endtask

    // Ticks until a rising frame_start is sampled; -1 on timeout
    task automatic wait_fs(output int n);
        logic prev;
        n = -1;
        prev = frame_start;
        for (int i = 1; i <= 2000; i++) begin
            tick(1);
            if (frame_start && !prev) begin
                n = i;
                break;
            end
            prev = frame_start;
        end
        if (n < 0) check("wait_frame_start_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stim
        int n, hs_cnt, vs_cnt, vid_cnt, ls_cnt, fs_cnt, first_hs, hold, budget;
        tick(1);
        chk_on = 1'b1;
        tick(1);
        check("rst_column", 32'(pixel_column), 32'd0);
        check("rst_hsync_idle", 32'(horiz_sync), 32'd1);
        check("rst_vsync_idle", 32'(vert_sync), 32'd0);
        check("rst_video_on", 32'(video_on), 32'd0);
        check("rst_running", 32'(running), 32'd0);

        rst = 1'b0;
        enable = 1'b1;
        wait_fs(n);
        check("first_fs_latency", 32'(n), 32'd1);

        // One full frame of literal counts
        hs_cnt = 0; vs_cnt = 0; vid_cnt = 0; ls_cnt = 0; fs_cnt = 0; first_hs = -1;
        for (int i = 0; i < FT; i++) begin
            if (horiz_sync == 1'b0) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(pixel_column);
            end
            if (vert_sync == 1'b1) vs_cnt++;
            if (video_on) vid_cnt++;
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            tick(1);
        end
        check("frame_len", 32'(frame_start), 32'd1);
        check("hs_ticks", 32'(hs_cnt), 32'd27);
        check("hs_first_col", 32'(first_hs), 32'd11);
        check("vs_ticks", 32'(vs_cnt), 32'd30);
        check("video_ticks", 32'(vid_cnt), 32'd30);
        check("line_starts", 32'(ls_cnt), 32'd9);
        check("frame_starts", 32'(fs_cnt), 32'd1);

        // Enable dropped at row 2, raised at row 4: frame must continue unbroken
        tick(2 * HT);
        enable = 1'b0;
        tick(2 * HT);
        enable = 1'b1;
        wait_fs(n);
        check("seamless_len", 32'(n), 32'd75);

        // Pixel enable 1-of-4
        div4 = 1'b1;
        wait_fs(n);
        wait_fs(n);
        check("div4_frame_clocks", 32'(n), 32'd540);
        hold = 0;
        while (frame_start && hold < 10) begin
            hold++;
            tick(1);
        end
        check("div4_strobe_hold", 32'(hold), 32'd4);
        div4 = 1'b0;

        // Drop and hold enable: halt at origin, no further frames
        enable = 1'b0;
        budget = 0;
        while (running && budget < 600) begin
            budget++;
            tick(1);
        end
        check("halt_running", 32'(running), 32'd0);
        check("halt_column", 32'(pixel_column), 32'd0);
        check("halt_row", 32'(pixel_row), 32'd0);
        check("halt_hsync", 32'(horiz_sync), 32'd1);
        check("halt_vsync", 32'(vert_sync), 32'd0);
        fs_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (frame_start) fs_cnt++;
        end
        check("no_restart", 32'(fs_cnt), 32'd0);

        // Three frames, then reset at row 3
        enable = 1'b1;
        for (int k = 0; k < 3; k++) wait_fs(n);
        tick(3 * HT);
        check("pre_rst_row", 32'(pixel_row), 32'd3);
        rst = 1'b1;
        tick(1);
        check("midrst_column", 32'(pixel_column), 32'd0);
        check("midrst_row", 32'(pixel_row), 32'd0);
        check("midrst_running", 32'(running), 32'd0);
        check("midrst_hsync", 32'(horiz_sync), 32'd1);
`ifdef DTG_FRAME_CNT_EN
        check("midrst_frame_count", 32'(frame_count), 32'd0);
`endif
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_fs(n);
            check("rerun_fs_spacing", 32'(n), (k == 1) ? 32'd1 : 32'(FT));
`ifdef DTG_FRAME_CNT_EN
            check("rerun_frame_count", 32'(frame_count), 32'(k));
`endif
        end

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
